serial_adder: RTL and testbench

Parametrised multi-cycle adder. It adds two WIDTH-bit operands plus carry-in, processing DIGIT bits per clock through a single DIGIT-bit ripple slice built from full-adder cells. It is the sequential, area-reduced successor to the single-bit full adder. It sits between an operand producer and a result consumer, using valid/ready handshakes on both sides.

---
 rtl/serial_adder_if.sv | 26 ++
 rtl/serial_adder.sv | 123 ++++++++++++
 tb/tb_serial_adder.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Valid/ready operand and result handshake bundle for serial_adder.
// master: operand producer / result consumer; slave: the adder itself.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder: DIGIT bits per clock through one ripple slice.
// Ports: clk, rst_n (async, active-low), bus (serial_adder_if.slave).
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad
            $error("serial_adder: DIGIT must be >= 1 and divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0]       a_q, b_q, sum_q;
    logic                   carry_q, cout_q, ovf_q;
    logic [CW-1:0]          k_q;
    logic [DIGIT-1:0]       dsum;
    logic [DIGIT:0]         c;
    logic [WIDTH+DIGIT-1:0] sum_cat;
    logic                   last;
    logic                   in_rdy, out_vld;

    assign last    = (k_q == CW'(N - 1));
    assign sum_cat = {dsum, sum_q};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (bus.in_valid)  state_n = RUN;
            RUN:  if (last)          state_n = DONE;
            DONE: if (bus.out_ready) state_n = IDLE;
            default:                 state_n = IDLE;
        endcase
    end

    // Handshake outputs decoded from state only
    always_comb begin
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        unique case (state)
            IDLE:    in_rdy  = 1'b1;
            DONE:    out_vld = 1'b1;
            default: ;
        endcase
    end

    // Ripple slice of full-adder cells on the low digit of the operands
    always_comb begin
        c    = '0;
        dsum = '0;
        c[0] = carry_q;
        for (int i = 0; i < DIGIT; i++) begin
            dsum[i]  = a_q[i] ^ b_q[i] ^ c[i];
            c[i+1]   = (a_q[i] & b_q[i]) | (c[i] & (a_q[i] ^ b_q[i]));
        end
    end

    // Datapath: operands shift right, sum fills from the top, so after
    // N digits the first digit computed lands at the LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        carry_q <= bus.cin;
                        k_q     <= '0;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    sum_q   <= sum_cat[WIDTH+DIGIT-1:DIGIT];
                    carry_q <= c[DIGIT];
                    k_q     <= k_q + 1'b1;
                    if (last) begin
                        // Top bit of the last digit is the operand/sum MSB
                        cout_q <= c[DIGIT];
                        ovf_q  <= (a_q[DIGIT-1] == b_q[DIGIT-1]) &&
                                  (dsum[DIGIT-1] != a_q[DIGIT-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three configurations (8/1, 8/4, 1/1) checked
// against a transaction-level model plus directed literal expectations.
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] iv;
    logic [7:0] a_s, b_s;
    logic       cin_s;
    logic       ordy;

    logic [2:0] ir, ov, co, vo;
    logic [7:0] so [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) if0 ();
    serial_adder_if #(.WIDTH(8)) if1 ();
    serial_adder_if #(.WIDTH(1)) if2 ();

    assign if0.in_valid  = iv[0];
    assign if0.a         = a_s;
    assign if0.b         = b_s;
    assign if0.cin       = cin_s;
    assign if0.out_ready = ordy;
    assign if1.in_valid  = iv[1];
    assign if1.a         = a_s;
    assign if1.b         = b_s;
    assign if1.cin       = cin_s;
    assign if1.out_ready = ordy;
    assign if2.in_valid  = iv[2];
    assign if2.a         = a_s[0];
    assign if2.b         = b_s[0];
    assign if2.cin       = cin_s;
    assign if2.out_ready = ordy;

    assign ir    = {if2.in_ready, if1.in_ready, if0.in_ready};
    assign ov    = {if2.out_valid, if1.out_valid, if0.out_valid};
    assign co    = {if2.cout, if1.cout, if0.cout};
    assign vo    = {if2.overflow, if1.overflow, if0.overflow};
    assign so[0] = if0.sum;
    assign so[1] = if1.sum;
    assign so[2] = {7'b0, if2.sum};

    serial_adder #(.WIDTH(8), .DIGIT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave)
    );
    serial_adder #(.WIDTH(8), .DIGIT(4)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave)
    );
    serial_adder #(.WIDTH(1), .DIGIT(1)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.slave)
    );

    function automatic int wid(input int i);
        return (i == 2) ? 1 : 8;
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 8 : (i == 1) ? 2 : 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Transaction model: one result per accepted operand set, visible
    // N edges after acceptance, gone on the edge it is taken.
    int m_busy [3];
    int m_age  [3];
    int m_sum  [3];
    int m_cout [3];
    int m_ovf  [3];

    always @(posedge clk or negedge rst_n) begin
        int w, msk, av, bv, s;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_busy[i] = 0;
                m_age[i]  = 0;
            end else if (m_busy[i] == 0) begin
                if (iv[i]) begin
                    w         = wid(i);
                    msk       = (1 << w) - 1;
                    av        = int'(a_s) & msk;
                    bv        = int'(b_s) & msk;
                    s         = av + bv + int'(cin_s);
                    m_sum[i]  = s & msk;
                    m_cout[i] = (s >> w) & 1;
                    m_ovf[i]  = (((av >> (w-1)) & 1) == ((bv >> (w-1)) & 1)) &&
                                (((m_sum[i] >> (w-1)) & 1) != ((av >> (w-1)) & 1));
                    m_busy[i] = 1;
                    m_age[i]  = 0;
                end
            end else if (m_age[i] < lat_of(i)) begin
                m_age[i]++;
            end else if (ordy) begin
                m_busy[i] = 0;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("m_ready%0d", i), 32'(ir[i]), 32'(m_busy[i] == 0));
            chk($sformatf("m_valid%0d", i), 32'(ov[i]),
                32'(m_busy[i] != 0 && m_age[i] == lat_of(i)));
            if (m_busy[i] != 0 && m_age[i] == lat_of(i)) begin
                chk($sformatf("m_sum%0d", i),  32'(so[i]), m_sum[i]);
                chk($sformatf("m_cout%0d", i), 32'(co[i]), m_cout[i]);
                chk($sformatf("m_ovf%0d", i),  32'(vo[i]), m_ovf[i]);
            end
        end
    end

    // Called at the negedge after the acceptance edge
    task automatic wait_done(input int idx, input logic [7:0] es,
                             input logic ec, input logic eo, input int lat);
        int k = 0;
        while (ov[idx] !== 1'b1 && k < 40) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        chk($sformatf("lat%0d", idx),  k, lat);
        chk($sformatf("sum%0d", idx),  32'(so[idx]), 32'(es));
        chk($sformatf("cout%0d", idx), 32'(co[idx]), 32'(ec));
        chk($sformatf("ovf%0d", idx),  32'(vo[idx]), 32'(eo));
    endtask

    task automatic run(input int idx, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic [7:0] es, input logic ec,
                       input logic eo, input int lat);
        @(negedge clk);
        a_s     = a;
        b_s     = b;
        cin_s   = c;
        iv[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[idx] = 1'b0;
        a_s     = 8'($urandom);
        b_s     = 8'($urandom);
        cin_s   = 1'($urandom);
        wait_done(idx, es, ec, eo, lat);
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [7:0] t_s, t_c, t_o;
    logic [2:0] j3;

    initial begin
        rst_n = 1'b0;
        iv    = '0;
        a_s   = '0;
        b_s   = '0;
        cin_s = 1'b0;
        ordy  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ir), 32'h7);
        chk("rst_valid", 32'(ov), 32'h0);
        chk("rst_sum",   32'(so[0]), 32'h0);
        chk("rst_cout",  32'(co), 32'h0);
        rst_n = 1'b1;

        run(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8);
        run(0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 8);
        run(0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 8);
        run(0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 8);
        run(1, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 2);
        run(1, 8'h64, 8'h64, 1'b0, 8'hC8, 1'b0, 1'b1, 2);

        // Full-adder truth table indexed by {a,b,cin}
        t_s = 8'b1001_0110;
        t_c = 8'b1110_1000;
        t_o = 8'b0100_0010;
        for (int j = 0; j < 8; j++) begin
            j3 = 3'(j);
            run(2, {7'b0, j3[2]}, {7'b0, j3[1]}, j3[0],
                {7'b0, t_s[j]}, t_c[j], t_o[j], 1);
        end

        // Backpressure with continuous in_valid and moving operands
        @(negedge clk);
        a_s   = 8'h11;
        b_s   = 8'h22;
        cin_s = 1'b0;
        iv[0] = 1'b1;
        ordy  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        wait_done(0, 8'h33, 1'b0, 1'b0, 8);
        for (int h = 0; h < 5; h++) begin
            a_s = 8'($urandom);
            b_s = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk("bp_sum",   32'(so[0]), 32'h33);
            chk("bp_cout",  32'(co[0]), 32'h0);
            chk("bp_valid", 32'(ov[0]), 32'h1);
            chk("bp_ready", 32'(ir[0]), 32'h0);
        end
        a_s  = 8'h05;
        b_s  = 8'h06;
        ordy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_retire_valid", 32'(ov[0]), 32'h0);
        chk("bp_retire_ready", 32'(ir[0]), 32'h1);
        @(posedge clk);
        @(negedge clk);
        chk("bp_accept_ready", 32'(ir[0]), 32'h0);
        iv[0] = 1'b0;
        wait_done(0, 8'h0B, 1'b0, 1'b0, 8);
        @(posedge clk);
        @(negedge clk);

        // Asynchronous reset three clocks into RUN
        a_s   = 8'h55;
        b_s   = 8'h0F;
        cin_s = 1'b0;
        iv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(ir[0]), 32'h1);
        chk("arst_valid", 32'(ov[0]), 32'h0);
        chk("arst_sum",   32'(so[0]), 32'h0);
        chk("arst_cout",  32'(co[0]), 32'h0);
        chk("arst_ovf",   32'(vo[0]), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired @%0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
